// File: rtl/gpio_apb_arb13.sv
`default_nettype none
// ============================================================================
// Module      : gpio_apb_arb13
// Description : Two-port arbiter that runs APB SETUP/ACCESS transfers to the
//               gpio13 slave on behalf of the CPU bridge and wakeup controller.
// Revision    : 1.0 - initial release
// ============================================================================
module gpio_apb_arb13 #(
    parameter bit FIXED_PRIO = 1'b0,
    parameter int AW         = 6
) (
    input  logic          pclk13,
    input  logic          p_reset13,
    input  logic          req0_13,
    input  logic          we0_13,
    input  logic [AW-1:0] addr0_13,
    input  logic [15:0]   wdata0_13,
    output logic          ack0_13,
    output logic          done0_13,
    output logic [15:0]   rdata0_13,
    input  logic          req1_13,
    input  logic          we1_13,
    input  logic [AW-1:0] addr1_13,
    input  logic [15:0]   wdata1_13,
    output logic          ack1_13,
    output logic          done1_13,
    output logic [15:0]   rdata1_13,
    output logic          psel13,
    output logic          penable13,
    output logic          pwrite13,
    output logic [AW-1:0] paddr13,
    output logic [31:0]   pwdata13,
    input  logic [31:0]   prdata13
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2
    } state_t;

    state_t      r_state;
    logic        r_last_grant;
    logic        r_cur;
    logic [15:0] r_wdata;
    logic        w_any_req;
    logic        w_grant;
    logic        w_unused_prdata;

    assign w_any_req       = req0_13 | req1_13;
    assign pwdata13        = {16'h0000, r_wdata};
    assign w_unused_prdata = ^prdata13[31:16];

    // A lone request always wins; a tie is settled by priority mode.
    always_comb begin
        w_grant = req1_13;
        if (req0_13 && req1_13) begin
            w_grant = FIXED_PRIO ? 1'b0 : ~r_last_grant;
        end
    end

    always_ff @(posedge pclk13 or posedge p_reset13) begin
        if (p_reset13) begin
            r_state      <= S_IDLE;
            r_last_grant <= 1'b1;
            r_cur        <= 1'b0;
            r_wdata      <= 16'h0000;
            psel13       <= 1'b0;
            penable13    <= 1'b0;
            pwrite13     <= 1'b0;
            paddr13      <= '0;
            ack0_13      <= 1'b0;
            ack1_13      <= 1'b0;
            done0_13     <= 1'b0;
            done1_13     <= 1'b0;
            rdata0_13    <= 16'h0000;
            rdata1_13    <= 16'h0000;
        end else begin
            ack0_13  <= 1'b0;
            ack1_13  <= 1'b0;
            done0_13 <= 1'b0;
            done1_13 <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_cur        <= w_grant;
                        r_last_grant <= w_grant;
                        pwrite13     <= w_grant ? we1_13    : we0_13;
                        paddr13      <= w_grant ? addr1_13  : addr0_13;
                        r_wdata      <= w_grant ? wdata1_13 : wdata0_13;
                        psel13       <= 1'b1;
                        ack0_13      <= ~w_grant;
                        ack1_13      <= w_grant;
                        r_state      <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    penable13 <= 1'b1;
                    r_state   <= S_ACCESS;
                end
                S_ACCESS: begin
                    psel13    <= 1'b0;
                    penable13 <= 1'b0;
                    done0_13  <= ~r_cur;
                    done1_13  <= r_cur;
                    if (!pwrite13) begin
                        if (r_cur) begin
                            rdata1_13 <= prdata13[15:0];
                        end else begin
                            rdata0_13 <= prdata13[15:0];
                        end
                    end
                    r_state <= S_IDLE;
                end
                default: begin
                    psel13    <= 1'b0;
                    penable13 <= 1'b0;
                    r_state   <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_gpio_apb_arb13.sv
`default_nettype none
// ============================================================================
// Module      : tb_gpio_apb_arb13
// Description : Self-checking bench for gpio_apb_arb13 with a gpio memory model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gpio_apb_arb13;
    localparam int AW = 6;

    logic          pclk13 = 1'b0;
    logic          p_reset13;
    logic          req0_13, we0_13, req1_13, we1_13;
    logic [AW-1:0] addr0_13, addr1_13;
    logic [15:0]   wdata0_13, wdata1_13;
    logic          ack0_13, done0_13, ack1_13, done1_13;
    logic [15:0]   rdata0_13, rdata1_13;
    logic          psel13, penable13, pwrite13;
    logic [AW-1:0] paddr13;
    logic [31:0]   pwdata13, prdata13;

    logic          fp_ack0, fp_done0, fp_ack1, fp_done1;
    logic [15:0]   fp_rdata0, fp_rdata1;
    logic          fp_psel, fp_penable, fp_pwrite;
    logic [AW-1:0] fp_paddr;
    logic [31:0]   fp_pwdata, fp_prdata;

    int errors = 0;
    int checks = 0;

    logic [31:0] gmem [0:63];
    logic [15:0] ref_mem [0:63];
    logic        bd_we;
    logic [5:0]  bd_addr;
    logic [31:0] bd_data;
    logic        model_last;

    always #5 pclk13 = ~pclk13;

    // gpio slave model: combinational read, write on the ACCESS edge
    assign prdata13  = gmem[paddr13];
    assign fp_prdata = 32'h0;
    always @(posedge pclk13) begin
        if (bd_we) gmem[bd_addr] <= bd_data;
        else if (psel13 && penable13 && pwrite13) gmem[paddr13] <= pwdata13;
    end

    gpio_apb_arb13 #(.FIXED_PRIO(1'b0), .AW(AW)) u_dut (
        .pclk13(pclk13), .p_reset13(p_reset13),
        .req0_13(req0_13), .we0_13(we0_13), .addr0_13(addr0_13), .wdata0_13(wdata0_13),
        .ack0_13(ack0_13), .done0_13(done0_13), .rdata0_13(rdata0_13),
        .req1_13(req1_13), .we1_13(we1_13), .addr1_13(addr1_13), .wdata1_13(wdata1_13),
        .ack1_13(ack1_13), .done1_13(done1_13), .rdata1_13(rdata1_13),
        .psel13(psel13), .penable13(penable13), .pwrite13(pwrite13),
        .paddr13(paddr13), .pwdata13(pwdata13), .prdata13(prdata13)
    );

    gpio_apb_arb13 #(.FIXED_PRIO(1'b1), .AW(AW)) u_fp (
        .pclk13(pclk13), .p_reset13(p_reset13),
        .req0_13(req0_13), .we0_13(we0_13), .addr0_13(addr0_13), .wdata0_13(wdata0_13),
        .ack0_13(fp_ack0), .done0_13(fp_done0), .rdata0_13(fp_rdata0),
        .req1_13(req1_13), .we1_13(we1_13), .addr1_13(addr1_13), .wdata1_13(wdata1_13),
        .ack1_13(fp_ack1), .done1_13(fp_done1), .rdata1_13(fp_rdata1),
        .psel13(fp_psel), .penable13(fp_penable), .pwrite13(fp_pwrite),
        .paddr13(fp_paddr), .pwdata13(fp_pwdata), .prdata13(fp_prdata)
    );

    task automatic tick();
        @(posedge pclk13);
        #1;
    endtask

    task automatic set_req(input int p, input logic we, input logic [5:0] a, input logic [15:0] d);
        if (p == 0) begin
            req0_13 = 1'b1; we0_13 = we; addr0_13 = a; wdata0_13 = d;
        end else begin
            req1_13 = 1'b1; we1_13 = we; addr1_13 = a; wdata1_13 = d;
        end
    endtask

    task automatic drop_req(input int p);
        if (p == 0) req0_13 = 1'b0;
        else        req1_13 = 1'b0;
    endtask

    // Drives one lone request and records what the bus and handshakes did.
    task automatic run_xfer(input int p, input logic we, input logic [5:0] a, input logic [15:0] d,
                            output int ack_c, output int done_c, output logic setup_ok,
                            output logic [15:0] rd, output logic acc_w,
                            output logic [5:0] acc_a, output logic [31:0] acc_d);
        ack_c = -1; done_c = -1; setup_ok = 1'b0; rd = 16'h0;
        acc_w = 1'b0; acc_a = 6'h0; acc_d = 32'h0;
        set_req(p, we, a, d);
        for (int c = 1; c <= 12 && done_c < 0; c++) begin
            tick();
            if (psel13 && penable13) begin
                acc_w = pwrite13; acc_a = paddr13; acc_d = pwdata13;
            end
            if ((p == 0 ? ack0_13 : ack1_13) && ack_c < 0) begin
                ack_c = c;
                setup_ok = psel13 && !penable13;
                drop_req(p);
            end
            if (p == 0 ? done0_13 : done1_13) begin
                done_c = c;
                rd = (p == 0) ? rdata0_13 : rdata1_13;
            end
        end
        drop_req(p);
    endtask

    task automatic test_reset();
        p_reset13 = 1'b1;
        req0_13 = 0; we0_13 = 0; addr0_13 = '0; wdata0_13 = '0;
        req1_13 = 0; we1_13 = 0; addr1_13 = '0; wdata1_13 = '0;
        bd_we = 0; bd_addr = '0; bd_data = '0;
        repeat (2) tick();
        checks++;
        if ({psel13, penable13, pwrite13, ack0_13, ack1_13, done0_13, done1_13} !== 7'b0)
            begin errors++; $display("FAIL reset_ctrl: got %b expected 0000000",
                {psel13, penable13, pwrite13, ack0_13, ack1_13, done0_13, done1_13}); end
        checks++;
        if (paddr13 !== 6'h0 || pwdata13 !== 32'h0)
            begin errors++; $display("FAIL reset_bus: paddr=%h pwdata=%h expected 0", paddr13, pwdata13); end
        checks++;
        if (rdata0_13 !== 16'h0 || rdata1_13 !== 16'h0)
            begin errors++; $display("FAIL reset_rdata: %h %h expected 0", rdata0_13, rdata1_13); end
        checks++;
        if ({fp_psel, fp_penable, fp_pwrite, fp_ack0, fp_ack1, fp_done0, fp_done1} !== 7'b0 ||
            fp_paddr !== 6'h0 || fp_pwdata !== 32'h0 || fp_rdata0 !== 16'h0 || fp_rdata1 !== 16'h0)
            begin errors++; $display("FAIL reset_fp: fixed-priority instance outputs not zero"); end
        for (int i = 0; i < 64; i++) begin
            bd_we = 1'b1;
            bd_addr = 6'(i);
            bd_data = (i == 8) ? 32'hDEAD_1234 : $urandom;
            ref_mem[i] = bd_data[15:0];
            tick();
        end
        bd_we = 1'b0;
        p_reset13 = 1'b0;
        model_last = 1'b1;
        tick();
        checks++;
        if (psel13 !== 1'b0 || ack0_13 !== 1'b0 || ack1_13 !== 1'b0)
            begin errors++; $display("FAIL reset_idle: psel=%b ack0=%b ack1=%b expected 0", psel13, ack0_13, ack1_13); end
    endtask

    task automatic test_basic_write();
        int ack_c, done_c; logic su; logic [15:0] rd; logic w; logic [5:0] a; logic [31:0] d;
        run_xfer(0, 1'b1, 6'h04, 16'h00F0, ack_c, done_c, su, rd, w, a, d);
        model_last = 1'b0;
        ref_mem[4] = 16'h00F0;
        checks++;
        if (ack_c !== 1 || su !== 1'b1)
            begin errors++; $display("FAIL write_ack: ack cycle %0d setup %b expected 1/1", ack_c, su); end
        checks++;
        if (w !== 1'b1 || a !== 6'h04 || d !== 32'h0000_00F0)
            begin errors++; $display("FAIL write_access: pwrite=%b paddr=%h pwdata=%h expected 1/04/000000f0", w, a, d); end
        checks++;
        if (done_c !== 3)
            begin errors++; $display("FAIL write_done: done cycle %0d expected 3", done_c); end
    endtask

    task automatic test_read_port1();
        int ack_c, done_c; logic su; logic [15:0] rd, prev0; logic w; logic [5:0] a; logic [31:0] d;
        prev0 = rdata0_13;
        run_xfer(1, 1'b0, 6'h08, 16'h0000, ack_c, done_c, su, rd, w, a, d);
        model_last = 1'b1;
        checks++;
        if (done_c !== 3 || rd !== 16'h1234)
            begin errors++; $display("FAIL read_p1: done cycle %0d rdata1=%h expected 3/1234", done_c, rd); end
        checks++;
        if (w !== 1'b0 || a !== 6'h08)
            begin errors++; $display("FAIL read_p1_bus: pwrite=%b paddr=%h expected 0/08", w, a); end
        repeat (2) tick();
        checks++;
        if (rdata1_13 !== 16'h1234 || rdata0_13 !== prev0)
            begin errors++; $display("FAIL read_p1_hold: rdata1=%h rdata0=%h expected 1234/%h", rdata1_13, rdata0_13, prev0); end
    endtask

    task automatic test_arbitration();
        logic exp_port;
        set_req(0, 1'b0, 6'h01, 16'h0);
        set_req(1, 1'b0, 6'h02, 16'h0);
        for (int c = 1; c <= 12; c++) begin
            tick();
            if (c % 3 == 1) begin
                exp_port = ~model_last;
                model_last = exp_port;
                checks++;
                if ({ack1_13, ack0_13} !== (exp_port ? 2'b10 : 2'b01))
                    begin errors++; $display("FAIL rr_grant c%0d: acks=%b expected port %0d", c, {ack1_13, ack0_13}, exp_port); end
                checks++;
                if ({fp_ack1, fp_ack0} !== 2'b01)
                    begin errors++; $display("FAIL fp_grant c%0d: acks=%b expected 01", c, {fp_ack1, fp_ack0}); end
            end else begin
                checks++;
                if ({ack1_13, ack0_13, fp_ack1, fp_ack0} !== 4'b0)
                    begin errors++; $display("FAIL arb_spacing c%0d: acks=%b expected 0000", c, {ack1_13, ack0_13, fp_ack1, fp_ack0}); end
            end
        end
        drop_req(0); drop_req(1);
        repeat (3) tick();
        checks++;
        if (rdata0_13 !== ref_mem[1] || rdata1_13 !== ref_mem[2])
            begin errors++; $display("FAIL arb_rdata: %h %h expected %h %h", rdata0_13, rdata1_13, ref_mem[1], ref_mem[2]); end
    endtask

    task automatic test_held_req();
        int n_ack = 0, n_done = 0, n_wr = 0, d1 = -1, d2 = -1;
        logic [15:0] dat;
        dat = 16'($urandom);
        set_req(0, 1'b1, 6'h10, dat);
        for (int c = 1; c <= 10; c++) begin
            tick();
            if (psel13 && penable13 && pwrite13) n_wr++;
            if (done0_13) begin
                n_done++;
                if (d1 < 0) d1 = c; else d2 = c;
            end
            if (ack0_13) begin
                n_ack++;
                if (n_ack == 2) drop_req(0);
            end
        end
        drop_req(0);
        model_last = 1'b0;
        ref_mem[16] = dat;
        checks++;
        if (n_ack !== 2 || n_done !== 2)
            begin errors++; $display("FAIL held_req_count: acks=%0d dones=%0d expected 2/2", n_ack, n_done); end
        checks++;
        if (d1 !== 3 || d2 !== 6)
            begin errors++; $display("FAIL held_req_timing: dones at %0d,%0d expected 3,6", d1, d2); end
        checks++;
        if (n_wr !== 2)
            begin errors++; $display("FAIL held_req_strobe: write strobes %0d expected 2", n_wr); end
    endtask

    task automatic test_write_read();
        int ack_c, done_c; logic su; logic [15:0] rd, dat; logic w; logic [5:0] a, adr; logic [31:0] d;
        adr = 6'h2A;
        dat = 16'($urandom);
        run_xfer(0, 1'b1, adr, dat, ack_c, done_c, su, rd, w, a, d);
        ref_mem[adr] = dat;
        run_xfer(0, 1'b0, adr, 16'h0, ack_c, done_c, su, rd, w, a, d);
        model_last = 1'b0;
        checks++;
        if (rd !== dat || done_c !== 3)
            begin errors++; $display("FAIL write_read: rdata0=%h done cycle %0d expected %h/3", rd, done_c, dat); end
    endtask

    task automatic test_random();
        logic w0, w1, we0, we1, exp_first, port, first_chk, dn0, dn1;
        logic [5:0] a0, a1;
        logic [15:0] d0, d1;
        int ac0, ac1;
        for (int it = 0; it < 30; it++) begin
            w0 = 1'($urandom); w1 = 1'($urandom);
            if (!w0 && !w1) w0 = 1'b1;
            we0 = 1'($urandom); we1 = 1'($urandom);
            a0 = 6'($urandom); a1 = 6'($urandom);
            d0 = 16'($urandom); d1 = 16'($urandom);
            if (w0) set_req(0, we0, a0, d0);
            if (w1) set_req(1, we1, a1, d1);
            exp_first = (w0 && w1) ? ~model_last : w1;
            first_chk = 1'b0; dn0 = !w0; dn1 = !w1; ac0 = -10; ac1 = -10;
            for (int c = 1; c <= 15 && !(dn0 && dn1); c++) begin
                tick();
                if (ack0_13 || ack1_13) begin
                    port = ack1_13;
                    if (!first_chk) begin
                        first_chk = 1'b1;
                        checks++;
                        if (port !== exp_first)
                            begin errors++; $display("FAIL rand_grant it%0d: granted %0d expected %0d", it, port, exp_first); end
                    end
                    model_last = port;
                    if (port) ac1 = c; else ac0 = c;
                    drop_req(int'(port));
                end
                if (done0_13) begin
                    dn0 = 1'b1;
                    checks++;
                    if (c !== ac0 + 2 || (!we0 && rdata0_13 !== ref_mem[a0]))
                        begin errors++; $display("FAIL rand_done0 it%0d: cycle %0d rdata %h expected %0d/%h", it, c, rdata0_13, ac0 + 2, ref_mem[a0]); end
                    if (we0) ref_mem[a0] = d0;
                end
                if (done1_13) begin
                    dn1 = 1'b1;
                    checks++;
                    if (c !== ac1 + 2 || (!we1 && rdata1_13 !== ref_mem[a1]))
                        begin errors++; $display("FAIL rand_done1 it%0d: cycle %0d rdata %h expected %0d/%h", it, c, rdata1_13, ac1 + 2, ref_mem[a1]); end
                    if (we1) ref_mem[a1] = d1;
                end
            end
            drop_req(0); drop_req(1);
            checks++;
            if (!(dn0 && dn1))
                begin errors++; $display("FAIL rand_timeout it%0d: done0=%b done1=%b expected 1/1", it, dn0, dn1); end
            tick();
        end
    endtask

    task automatic test_async_reset();
        int ack_c, done_c; logic su; logic [15:0] rd; logic w; logic [5:0] a; logic [31:0] d;
        int n_done = 0;
        repeat (2) tick();
        set_req(1, 1'b1, 6'h20, 16'hA5A5);
        tick();
        tick();
        checks++;
        if (psel13 !== 1'b1 || penable13 !== 1'b1)
            begin errors++; $display("FAIL areset_pre: psel=%b penable=%b expected 1/1", psel13, penable13); end
        #2 p_reset13 = 1'b1;
        #1;
        checks++;
        if (psel13 !== 1'b0 || penable13 !== 1'b0)
            begin errors++; $display("FAIL areset_async: psel=%b penable=%b expected 0/0", psel13, penable13); end
        repeat (2) begin
            tick();
            if (done0_13 || done1_13) n_done++;
        end
        p_reset13 = 1'b0;
        model_last = 1'b1;
        checks++;
        if (n_done !== 0 || rdata1_13 !== 16'h0 || gmem[32][15:0] !== ref_mem[32])
            begin errors++; $display("FAIL areset_discard: dones=%0d rdata1=%h mem=%h expected 0/0000/%h", n_done, rdata1_13, gmem[32][15:0], ref_mem[32]); end
        run_xfer(1, 1'b1, 6'h20, 16'hA5A5, ack_c, done_c, su, rd, w, a, d);
        ref_mem[32] = 16'hA5A5;
        checks++;
        if (ack_c !== 1 || done_c !== 3 || w !== 1'b1 || a !== 6'h20 || d !== 32'h0000_A5A5)
            begin errors++; $display("FAIL areset_resume: ack %0d done %0d w=%b a=%h d=%h expected 1/3/1/20/0000a5a5", ack_c, done_c, w, a, d); end
    endtask

    initial begin
        test_reset();
        test_basic_write();
        test_read_port1();
        test_arbitration();
        test_held_req();
        test_write_read();
        test_random();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
